// File: rtl/issue_rr_arbiter.sv
// issue_rr_arbiter: round-robin picker feeding two registered issue ports from a reservation station
module issue_rr_arbiter #(
    parameter int REQ_NUM = 8,
    parameter int SEL_W   = 3
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_flush,
    input  logic [REQ_NUM-1:0] i_req,
    input  logic [1:0]         i_port_ready,
    output logic [REQ_NUM-1:0] o_grant,
    output logic [1:0]         o_issue_vld,
    output logic [SEL_W-1:0]   o_issue_sel0,
    output logic [SEL_W-1:0]   o_issue_sel1,
    output logic [SEL_W-1:0]   o_ptr
);
    logic [SEL_W-1:0] ptr_q, ptr_d, sel0_q, sel0_d, sel1_q, sel1_d;
    logic [1:0]       vld_q, vld_d;
    logic [1:0]       open_port, asg;
    logic             a_vld, b_vld;
    logic [SEL_W-1:0] a_idx, b_idx, idx, p1_idx, last_idx;

    // find the first two requesters in circular order starting at the pointer
    always_comb begin
        a_vld = 1'b0;
        b_vld = 1'b0;
        a_idx = '0;
        b_idx = '0;
        idx   = '0;
        for (int i = 0; i < REQ_NUM; i++) begin
            idx = (int'(ptr_q) + i >= REQ_NUM) ? SEL_W'(int'(ptr_q) + i - REQ_NUM) : SEL_W'(int'(ptr_q) + i);
            if (i_req[idx] && a_vld && !b_vld) begin
                b_vld = 1'b1;
                b_idx = idx;
            end
            if (i_req[idx] && !a_vld) begin
                a_vld = 1'b1;
                a_idx = idx;
            end
        end
    end

    // hand A to the lowest open port, B to port 1 only when both ports are open
    always_comb begin
        open_port = {2{i_rst_n && !i_flush}} & (~vld_q | i_port_ready);
        asg[0]    = open_port[0] && a_vld;
        asg[1]    = open_port[0] ? (open_port[1] && b_vld) : (open_port[1] && a_vld);
        p1_idx    = open_port[0] ? b_idx : a_idx;
        last_idx  = asg[1] ? p1_idx : a_idx;
        o_grant   = '0;
        if (asg[0]) o_grant[a_idx] = 1'b1;
        if (asg[1]) o_grant[p1_idx] = 1'b1;
    end

    // next-state: load on assignment, drain on accept, hold on stall, drop on flush
    always_comb begin
        ptr_d  = (|asg) ? ((last_idx == SEL_W'(REQ_NUM - 1)) ? '0 : last_idx + 1'b1) : ptr_q;
        vld_d  = i_flush ? 2'b00 : (asg | (vld_q & ~i_port_ready));
        sel0_d = asg[0] ? a_idx : sel0_q;
        sel1_d = asg[1] ? p1_idx : sel1_q;
    end

    // issue registers and priority pointer
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ptr_q  <= '0;
            vld_q  <= 2'b00;
            sel0_q <= '0;
            sel1_q <= '0;
        end else begin
            ptr_q  <= ptr_d;
            vld_q  <= vld_d;
            sel0_q <= sel0_d;
            sel1_q <= sel1_d;
        end
    end

    assign o_issue_vld  = vld_q;
    assign o_issue_sel0 = sel0_q;
    assign o_issue_sel1 = sel1_q;
    assign o_ptr        = ptr_q;
endmodule

// File: tb/tb_issue_rr_arbiter.sv
// tb_issue_rr_arbiter: directed vectors against literal expectations plus a queue-based reference model
module tb_issue_rr_arbiter;
    localparam int N = 8;
    logic         i_clk = 1'b0, i_rst_n = 1'b0, i_flush = 1'b0;
    logic [N-1:0] i_req = '0;
    logic [1:0]   i_port_ready = 2'b00;
    logic [N-1:0] o_grant;
    logic [1:0]   o_issue_vld;
    logic [2:0]   o_issue_sel0, o_issue_sel1, o_ptr;
    int checks = 0, errors = 0;

    issue_rr_arbiter #(.REQ_NUM(N), .SEL_W(3)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_flush(i_flush), .i_req(i_req),
        .i_port_ready(i_port_ready), .o_grant(o_grant), .o_issue_vld(o_issue_vld),
        .o_issue_sel0(o_issue_sel0), .o_issue_sel1(o_issue_sel1), .o_ptr(o_ptr)
    );

    always #5 i_clk = ~i_clk;

    // reference model state
    int         m_ptr, m_sel0, m_sel1;
    logic [1:0] m_vld;
    logic [N-1:0] e_grant;
    logic [1:0] e_asg;
    int         e_ns0, e_ns1, e_np;

    function automatic void model(input logic [N-1:0] req, input logic [1:0] rdy, input logic fl, input logic rstn,
                                  input int ptr, input logic [1:0] vld,
                                  output logic [N-1:0] g, output logic [1:0] a, output int ns0, output int ns1, output int np);
        int cand[$];
        int ports[$];
        g = '0; a = 2'b00; ns0 = 0; ns1 = 0; np = ptr;
        if (rstn && !fl) begin
            for (int i = 0; i < N; i++) if (req[(ptr + i) % N]) cand.push_back((ptr + i) % N);
            for (int k = 0; k < 2; k++) if (!vld[k] || rdy[k]) ports.push_back(k);
            for (int n = 0; n < cand.size() && n < ports.size(); n++) begin
                a[ports[n]] = 1'b1;
                if (ports[n] == 0) ns0 = cand[n]; else ns1 = cand[n];
                g[cand[n]] = 1'b1;
                np = (cand[n] + 1) % N;
            end
        end
    endfunction

    always_comb model(i_req, i_port_ready, i_flush, i_rst_n, m_ptr, m_vld, e_grant, e_asg, e_ns0, e_ns1, e_np);

    always @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            m_ptr <= 0; m_vld <= 2'b00; m_sel0 <= 0; m_sel1 <= 0;
        end else begin
            m_ptr <= e_np;
            for (int k = 0; k < 2; k++)
                m_vld[k] <= i_flush ? 1'b0 : e_asg[k] ? 1'b1 : (m_vld[k] && !i_port_ready[k]);
            if (e_asg[0]) m_sel0 <= e_ns0;
            if (e_asg[1]) m_sel1 <= e_ns1;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // per-cycle comparison against the model, away from the active edge
    always @(negedge i_clk) begin
        chk("m_grant", 32'(o_grant), 32'(e_grant));
        chk("m_vld", 32'(o_issue_vld), 32'(m_vld));
        chk("m_sel0", 32'(o_issue_sel0), 32'(m_sel0));
        chk("m_sel1", 32'(o_issue_sel1), 32'(m_sel1));
        chk("m_ptr", 32'(o_ptr), 32'(m_ptr));
    end

    task automatic drive(input logic [N-1:0] r, input logic [1:0] rd, input logic f);
        @(posedge i_clk); #1;
        i_req = r; i_port_ready = rd; i_flush = f;
        @(negedge i_clk);
    endtask

    task automatic expect_st(input string nm, input logic [1:0] v, input logic [2:0] s0, input logic [2:0] s1,
                             input logic [2:0] p, input logic [N-1:0] g);
        chk({nm, "_vld"}, 32'(o_issue_vld), 32'(v));
        chk({nm, "_ptr"}, 32'(o_ptr), 32'(p));
        chk({nm, "_grant"}, 32'(o_grant), 32'(g));
        if (v[0]) chk({nm, "_sel0"}, 32'(o_issue_sel0), 32'(s0));
        if (v[1]) chk({nm, "_sel1"}, 32'(o_issue_sel1), 32'(s1));
    endtask

    initial begin
        repeat (2) @(negedge i_clk);
        expect_st("reset", 2'b00, 3'd0, 3'd0, 3'd0, 8'h00);
        chk("reset_sel0", 32'(o_issue_sel0), 32'd0);
        chk("reset_sel1", 32'(o_issue_sel1), 32'd0);
        @(posedge i_clk); #1;
        i_rst_n = 1'b1; i_req = 8'b1000_0101; i_port_ready = 2'b11;
        @(negedge i_clk);
        expect_st("first", 2'b00, 3'd0, 3'd0, 3'd0, 8'b0000_0101);
        drive(8'h18, 2'b11, 1'b0); expect_st("two_load", 2'b11, 3'd0, 3'd2, 3'd3, 8'h18);
        drive(8'h20, 2'b11, 1'b0); expect_st("single", 2'b11, 3'd3, 3'd4, 3'd5, 8'h20);
        drive(8'h41, 2'b11, 1'b0); expect_st("wrap", 2'b01, 3'd5, 3'd4, 3'd6, 8'h41);
        drive(8'h10, 2'b11, 1'b0); expect_st("after_wrap", 2'b11, 3'd6, 3'd0, 3'd1, 8'h10);
        drive(8'h08, 2'b10, 1'b0); expect_st("port1_only", 2'b01, 3'd4, 3'd0, 3'd5, 8'h08);
        for (int i = 0; i < 5; i++) begin
            drive(8'hFF, 2'b00, 1'b0); expect_st("stall", 2'b11, 3'd4, 3'd3, 3'd4, 8'h00);
        end
        drive(8'hFF, 2'b11, 1'b0); expect_st("unstall", 2'b11, 3'd4, 3'd3, 3'd4, 8'h30);
        drive(8'hFF, 2'b11, 1'b1); expect_st("flush", 2'b11, 3'd4, 3'd5, 3'd6, 8'h00);
        drive(8'h18, 2'b11, 1'b0); expect_st("post_flush", 2'b00, 3'd4, 3'd5, 3'd6, 8'h18);
        drive(8'hFF, 2'b01, 1'b0); expect_st("pre_rst", 2'b11, 3'd3, 3'd4, 3'd5, 8'h20);
        #2 i_rst_n = 1'b0;
        #1;
        expect_st("async_rst", 2'b00, 3'd0, 3'd0, 3'd0, 8'h00);
        chk("async_rst_sel0", 32'(o_issue_sel0), 32'd0);
        chk("async_rst_sel1", 32'(o_issue_sel1), 32'd0);
        repeat (2) @(negedge i_clk);
        @(posedge i_clk); #1;
        i_rst_n = 1'b1;
        for (int i = 0; i < 300; i++)
            drive(N'($urandom), 2'($urandom), ($urandom_range(0, 15) == 0));
        drive('0, 2'b11, 1'b0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
